// File: rtl/max7219_receiver_if.sv
// SPI bus between a MAX7219 driver (master) and the receiver model (slave).
// The slave-side signal names match the MAX7219 receiver port names.
interface max7219_receiver_if;
  logic i_spi_sclk;
  logic i_spi_din;
  logic i_spi_cs_n;
  logic o_spi_dout;

  modport master (
    output i_spi_sclk,
    output i_spi_din,
    output i_spi_cs_n,
    input  o_spi_dout
  );

  modport slave (
    input  i_spi_sclk,
    input  i_spi_din,
    input  i_spi_cs_n,
    output o_spi_dout
  );
endinterface

// File: rtl/max7219_receiver.sv
// Receive-side MAX7219 model: deserializes 16-bit SPI frames, decodes them
// into the register set and exposes a registered digit read port.
module max7219_receiver (
  input  logic                i_clk,
  input  logic                i_reset_n,
  max7219_receiver_if.slave   spi,
  output logic                o_frame_stb,
  output logic                o_frame_err,
  output logic [3:0]          o_frame_addr,
  output logic [7:0]          o_frame_data,
  output logic [7:0]          o_decode_mode,
  output logic [3:0]          o_intensity,
  output logic [2:0]          o_scan_limit,
  output logic                o_enable,
  output logic                o_display_test,
  input  logic [2:0]          i_rd_digit,
  output logic [7:0]          o_rd_segment
);

  logic        sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic        sclk_s1_d, sclk_s2_d, sclk_prev_d;
  logic        din_s1_q, din_s2_q;
  logic        din_s1_d, din_s2_d;
  logic        cs_s1_q, cs_s2_q, cs_prev_q;
  logic        cs_s1_d, cs_s2_d, cs_prev_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        dout_q, dout_d;
  logic        stb_q, stb_d;
  logic        err_q, err_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  decode_q, decode_d;
  logic [3:0]  intens_q, intens_d;
  logic [2:0]  scan_q, scan_d;
  logic        enable_q, enable_d;
  logic        test_q, test_d;
  logic [7:0]  digit_q [8];
  logic [7:0]  digit_d [8];
  logic [7:0]  seg_q, seg_d;

  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [2:0]  wr_idx;

  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s2_q & sclk_prev_q;
  assign cs_rise   = cs_s2_q & ~cs_prev_q;
  assign cs_fall   = ~cs_s2_q & cs_prev_q;
  // Addresses 1..8 map onto digit slots 0..7; 3-bit wrap turns 8 into 7.
  assign wr_idx    = 3'(shift_q[10:8] - 3'd1);

  always_comb begin
    sclk_s1_d   = spi.i_spi_sclk;
    sclk_s2_d   = sclk_s1_q;
    sclk_prev_d = sclk_s2_q;
    din_s1_d    = spi.i_spi_din;
    din_s2_d    = din_s1_q;
    cs_s1_d     = spi.i_spi_cs_n;
    cs_s2_d     = cs_s1_q;
    cs_prev_d   = cs_s2_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    dout_d      = dout_q;
    stb_d       = 1'b0;
    err_d       = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    decode_d    = decode_q;
    intens_d    = intens_q;
    scan_d      = scan_q;
    enable_d    = enable_q;
    test_d      = test_q;
    digit_d     = digit_q;
    seg_d       = digit_q[i_rd_digit];

    // A cs_n rise wins over a coincident sclk rise, so that bit is dropped.
    if (cs_rise) begin
      if (bit_cnt_q != 5'd0) begin
        stb_d  = 1'b1;
        err_d  = (bit_cnt_q < 5'd16);
        addr_d = shift_q[11:8];
        data_d = shift_q[7:0];
        if (bit_cnt_q >= 5'd16) begin
          case (shift_q[11:8])
            4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8: digit_d[wr_idx] = shift_q[7:0];
            4'h9:    decode_d = shift_q[7:0];
            4'hA:    intens_d = shift_q[3:0];
            4'hB:    scan_d   = shift_q[2:0];
            4'hC:    enable_d = shift_q[0];
            4'hF:    test_d   = shift_q[0];
            default: ;
          endcase
        end
      end
    end else if (cs_fall) begin
      bit_cnt_d = 5'd0;
    end else if (sclk_rise && !cs_s2_q) begin
      shift_d = {shift_q[14:0], din_s2_q};
      if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
    end

    if (sclk_fall && !cs_s2_q) dout_d = shift_q[15];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      din_s1_q    <= 1'b0;
      din_s2_q    <= 1'b0;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_prev_q   <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      dout_q      <= 1'b0;
      stb_q       <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      decode_q    <= '0;
      intens_q    <= '0;
      scan_q      <= '0;
      enable_q    <= 1'b0;
      test_q      <= 1'b0;
      for (int i = 0; i < 8; i++) digit_q[i] <= '0;
      seg_q       <= '0;
    end else begin
      sclk_s1_q   <= sclk_s1_d;
      sclk_s2_q   <= sclk_s2_d;
      sclk_prev_q <= sclk_prev_d;
      din_s1_q    <= din_s1_d;
      din_s2_q    <= din_s2_d;
      cs_s1_q     <= cs_s1_d;
      cs_s2_q     <= cs_s2_d;
      cs_prev_q   <= cs_prev_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      dout_q      <= dout_d;
      stb_q       <= stb_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      decode_q    <= decode_d;
      intens_q    <= intens_d;
      scan_q      <= scan_d;
      enable_q    <= enable_d;
      test_q      <= test_d;
      for (int i = 0; i < 8; i++) digit_q[i] <= digit_d[i];
      seg_q       <= seg_d;
    end
  end

  assign spi.o_spi_dout    = dout_q;
  assign o_frame_stb       = stb_q;
  assign o_frame_err       = err_q;
  assign o_frame_addr      = addr_q;
  assign o_frame_data      = data_q;
  assign o_decode_mode     = decode_q;
  assign o_intensity       = intens_q;
  assign o_scan_limit      = scan_q;
  assign o_enable          = enable_q;
  assign o_display_test    = test_q;
  assign o_rd_segment      = seg_q;

endmodule

// File: tb/tb_max7219_receiver.sv
// Scoreboard bench for max7219_receiver: frames are modelled as they are
// driven, expected strobes are queued and popped when the DUT strobes.
module tb_max7219_receiver;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       o_frame_stb, o_frame_err, o_enable, o_display_test;
  logic [3:0] o_frame_addr, o_intensity;
  logic [7:0] o_frame_data, o_decode_mode, o_rd_segment;
  logic [2:0] o_scan_limit;
  logic [2:0] rd_digit = 3'd0;

  always #5 clk = ~clk;

  max7219_receiver_if spi ();

  max7219_receiver dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .spi            (spi),
    .o_frame_stb    (o_frame_stb),
    .o_frame_err    (o_frame_err),
    .o_frame_addr   (o_frame_addr),
    .o_frame_data   (o_frame_data),
    .o_decode_mode  (o_decode_mode),
    .o_intensity    (o_intensity),
    .o_scan_limit   (o_scan_limit),
    .o_enable       (o_enable),
    .o_display_test (o_display_test),
    .i_rd_digit     (rd_digit),
    .o_rd_segment   (o_rd_segment)
  );

  typedef struct packed {
    logic       err;
    logic [3:0] addr;
    logic [7:0] data;
  } frm_t;

  frm_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  logic [15:0] m_sh;
  logic [7:0]  m_dig [8];
  logic [7:0]  m_dec;
  logic [3:0]  m_int;
  logic [2:0]  m_scan;
  logic        m_en, m_test;
  int          rd_prev = 0;

  logic [39:0] all_outs;
  assign all_outs = {o_frame_stb, o_frame_err, o_frame_addr, o_frame_data,
                     o_decode_mode, o_intensity, o_scan_limit, o_enable,
                     o_display_test, o_rd_segment, spi.o_spi_dout};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    frm_t e;
    if (rst_n && o_frame_stb) begin
      if (sb.size() == 0) begin
        chk("stb_spurious", 64'(o_frame_stb), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("frm_err",  64'(o_frame_err),  64'(e.err));
        chk("frm_addr", 64'(o_frame_addr), 64'(e.addr));
        chk("frm_data", 64'(o_frame_data), 64'(e.data));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_sh = '0; m_dec = '0; m_int = '0; m_scan = '0; m_en = 1'b0; m_test = 1'b0;
    for (int i = 0; i < 8; i++) m_dig[i] = '0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [7:0] d);
    case (a)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: m_dig[int'(a) - 1] = d;
      4'h9: m_dec = d;
      4'hA: m_int = d[3:0];
      4'hB: m_scan = d[2:0];
      4'hC: m_en = d[0];
      4'hF: m_test = d[0];
      default: ;
    endcase
  endtask

  task automatic spi_bit(input logic b, input logic do_chk, input logic exp_dout);
    spi.i_spi_din = b;
    cyc(H);
    if (do_chk) chk("dout", 64'(spi.o_spi_dout), 64'(exp_dout));
    spi.i_spi_sclk = 1'b1;
    cyc(H);
    spi.i_spi_sclk = 1'b0;
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n);
    logic b, ed;
    for (int k = 0; k < n; k++) begin
      b  = w[n - 1 - k];
      ed = 1'b0;
      if (k >= 16) ed = w[n + 15 - k];
      spi_bit(b, k >= 16, ed);
      m_sh = {m_sh[14:0], b};
    end
  endtask

  task automatic push_latch(input int n);
    frm_t f;
    if (n > 0) begin
      f.err  = (n < 16);
      f.addr = m_sh[11:8];
      f.data = m_sh[7:0];
      sb.push_back(f);
      if (n >= 16) model_write(m_sh[11:8], m_sh[7:0]);
    end
  endtask

  task automatic cs_rise();
    cyc(H);
    spi.i_spi_cs_n = 1'b1;
    cyc(3 * H);
  endtask

  task automatic send_frame(input logic [31:0] w, input int n);
    spi.i_spi_cs_n = 1'b0;
    cyc(H);
    shift_bits(w, n);
    push_latch(n);
    cs_rise();
  endtask

  task automatic check_regs();
    chk("decode",  64'(o_decode_mode),  64'(m_dec));
    chk("intens",  64'(o_intensity),    64'(m_int));
    chk("scan",    64'(o_scan_limit),   64'(m_scan));
    chk("enable",  64'(o_enable),       64'(m_en));
    chk("disptst", 64'(o_display_test), 64'(m_test));
  endtask

  task automatic read_digits();
    for (int d = 0; d < 8; d++) begin
      rd_digit = 3'(d);
      #1;
      chk("rd_old", 64'(o_rd_segment), 64'(m_dig[rd_prev]));
      cyc(1);
      chk("rd_new", 64'(o_rd_segment), 64'(m_dig[d]));
      rd_prev = d;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] dig_tab [8];
    dig_tab = '{8'h55, 8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77, 8'hAA};
    spi.i_spi_sclk = 1'b0;
    spi.i_spi_din  = 1'b0;
    spi.i_spi_cs_n = 1'b1;
    model_reset();

    cyc(4);
    chk("reset_outs", 64'(all_outs), 64'd0);
    rst_n = 1'b1;
    cyc(4);
    chk("post_reset_outs", 64'(all_outs), 64'd0);

    // Single frame with latch latency and register update timing.
    spi.i_spi_cs_n = 1'b0;
    cyc(H);
    shift_bits(32'h0A07, 16);
    push_latch(16);
    cyc(H);
    spi.i_spi_cs_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc(1);
      chk("stb_lat", 64'(o_frame_stb), 64'(c == 3));
      chk("int_lat", 64'(o_intensity), (c >= 3) ? 64'd7 : 64'd0);
    end
    cyc(3 * H);
    check_regs();

    // Full configuration followed by all eight digits.
    send_frame(32'h09FF, 16);
    send_frame(32'h0A0F, 16);
    send_frame(32'h0B07, 16);
    send_frame(32'h0C01, 16);
    send_frame(32'h0F00, 16);
    for (int d = 0; d < 8; d++) send_frame({20'h0, 4'(d + 1), dig_tab[d]}, 16);
    check_regs();
    read_digits();

    // Short frame to digit 3 and an empty cs_n pulse.
    send_frame(32'h0399, 12);
    spi.i_spi_cs_n = 1'b0;
    cyc(H);
    cs_rise();
    read_digits();

    // Two frames in one window: only the last one reaches the registers.
    send_frame(32'h0C01_0B05, 32);
    check_regs();

    // sclk rise coincident with cs_n rise, then sclk activity with cs_n high.
    spi.i_spi_cs_n = 1'b0;
    cyc(H);
    shift_bits(32'h0A03, 16);
    push_latch(16);
    spi.i_spi_din = 1'b1;
    cyc(H);
    spi.i_spi_sclk = 1'b1;
    spi.i_spi_cs_n = 1'b1;
    cyc(H);
    spi.i_spi_sclk = 1'b0;
    cyc(2 * H);
    repeat (5) begin
      cyc(H);
      spi.i_spi_sclk = 1'b1;
      cyc(H);
      spi.i_spi_sclk = 1'b0;
    end
    cyc(H);
    check_regs();
    send_frame(32'h5, 4);

    // Reset in the middle of a frame.
    spi.i_spi_cs_n = 1'b0;
    cyc(H);
    for (int k = 7; k >= 0; k--) spi_bit(1'(8'hA5 >> k), 1'b0, 1'b0);
    cyc(2);
    rst_n = 1'b0;
    cyc(2);
    chk("midrst_outs", 64'(all_outs), 64'd0);
    cyc(2);
    rst_n = 1'b1;
    model_reset();
    cyc(2);
    chk("midrst_rel_outs", 64'(all_outs), 64'd0);
    cyc(H);
    shift_bits(32'h3C, 8);
    push_latch(8);
    cs_rise();
    check_regs();
    rd_prev = 0;
    read_digits();

    cyc(10);
    chk("sb_pending", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/max7219_receiver.md
# max7219_receiver

Synthesizable receive-side model of a MAX7219 LED driver. It deserializes 16-bit SPI frames (address in bits [11:8], data in bits [7:0], MSB first) and decodes them into the MAX7219 register set. It exposes the decoded registers, a per-frame strobe, and a digit read port. It sits on the far end of the settings/SPI driver chain, where it serves as an on-chip loopback target and a reference monitor for display-path verification.

## Interface
Parameters: none.
- i_clk  input  1  system clock (~50 MHz); all logic on rising edge
- i_reset_n  input  1  reset, synchronous, active-low
- i_spi_sclk  input  1  SPI clock (async to i_clk); data shifted on rising edge
- i_spi_din  input  1  SPI serial data
- i_spi_cs_n  input  1  chip select / LOAD, active-low; frame latched on rising edge
- o_spi_dout  output  1  daisy-chain out: shift-register bit 15
- o_frame_stb  output  1  one-cycle pulse per completed frame
- o_frame_err  output  1  valid with o_frame_stb; frame had 1..15 bits
- o_frame_addr  output  4  address of last frame (bits [11:8])
- o_frame_data  output  8  data of last frame (bits [7:0])
- o_decode_mode  output  8  register 0x9
- o_intensity  output  4  register 0xA, data[3:0]
- o_scan_limit  output  3  register 0xB, data[2:0]
- o_enable  output  1  register 0xC, data[0] (0 = shutdown)
- o_display_test  output  1  register 0xF, data[0]
- i_rd_digit  input  3  digit select for read port (0 = address 0x1)
- o_rd_segment  output  8  digit register contents, registered

## Operation
- Input sync: i_spi_sclk, i_spi_din, i_spi_cs_n each pass through a 2-flop synchronizer, plus a third "previous" flop on sclk and cs_n for edge detection. Din uses the same depth, so it stays aligned with sclk.
- Shift: on a synchronized sclk rising edge with cs_n low, shift_reg[15:0] <= {shift_reg[14:0], din}.
  - bit_cnt[4:0] increments and saturates at 31.
  - sclk edges while cs_n is high are ignored.
- The shift register is never cleared by cs_n, which preserves daisy-chain behaviour. Only reset clears it.
- cs_n falling edge: bit_cnt <= 0.
- cs_n rising edge (latch):
  - bit_cnt == 0: frame ignored; no strobe, no write.
  - bit_cnt 1..15: o_frame_stb = 1, o_frame_err = 1, addr/data outputs updated from shift_reg; no register write.
  - bit_cnt >= 16: o_frame_stb = 1, o_frame_err = 0, and the register addressed by shift_reg[11:8] is written. Bits [15:12] are ignored.
- Address decode:
  - 0x1..0x8: digit[addr-1] <= data.
  - 0x9: decode_mode <= data.
  - 0xA: intensity <= data[3:0].
  - 0xB: scan_limit <= data[2:0].
  - 0xC: enable <= data[0].
  - 0xF: display_test <= data[0].
  - 0x0, 0xD, 0xE: no-op, but the strobe is still issued.
- No BCD decoding is performed. Register contents are raw.
- o_spi_dout updates on the synchronized sclk falling edge (cs_n low) to shift_reg[15].
- Read port: o_rd_segment <= digit[i_rd_digit] every cycle.

## Timing
- Reset (i_reset_n low at a rising edge) clears all state and all outputs to 0. This includes all digits, shift_reg, bit_cnt, and the sync flops (which are set to idle: cs_n = 1, sclk = 0).
- Reset mid-frame abandons the frame. If cs_n is still low afterward, later bits count from 0; a cs_n rise with 1..15 bits reports an error.
- Latch latency: cs_n rising is first sampled high at edge k. o_frame_stb is high for exactly the cycle following edge k+2. Register outputs update at that same edge k+2.
- Shift latency: a sclk rise sampled at edge k shifts at edge k+2.
- SPI constraints: sclk high and low time each >= 3 i_clk periods. cs_n setup/hold to sclk edges >= 3 i_clk periods. Violations are unsupported.
- Simultaneous synchronized sclk rise and cs_n rise in the same cycle: cs_n has priority and the sclk edge is discarded.
- Read port: 1-cycle latency. Reading a digit in the same cycle it is written returns the old value; the new value appears one cycle later.
- o_frame_addr/o_frame_data hold their value until the next strobe.

## Test plan
- Single frame 0x0A07 (16 clocks) -> one o_frame_stb, err = 0, addr = 0xA, data = 0x07, o_intensity = 7; all other registers unchanged.
- Full config sequence (0x09FF, 0x0A0F, 0x0B07, 0x0C01, 0x0F00), then digits 0x0155..0x08AA -> decode = 0xFF, intensity = 0xF, scan = 7, enable = 1, test = 0. Reading digits 0..7 returns the written values with 1-cycle latency.
- Short frame of 12 bits to address 0x3 -> stb with err = 1; digit[2] unchanged. A cs_n pulse with no clocks -> no strobe.
- Daisy chain: 32 bits (0x0C01 then 0x0B05) in one cs_n window -> scan_limit = 5, enable unchanged. o_spi_dout reproduces 0x0C01 MSB first, starting after bit 16.
- Reset asserted mid-frame after 8 bits, released, then 8 more bits and cs_n rise -> err = 1, no write. All outputs read 0 during and after reset.
- sclk toggling with cs_n high, and a sclk rise coincident with the cs_n rise -> no shift occurs and bit_cnt is unaffected; the coincident frame latches 16 bits, not 17.
